// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - fetch/debug arbiter for the shared instruction-memory read port
// Fetch has priority; a saturating starvation counter forces a debug grant after MAX_FETCH_RUN refusals.
module imem_arbiter #(
    parameter int unsigned MAX_FETCH_RUN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req_valid,
    output logic        f_req_ready,
    input  logic [31:0] f_req_addr,
    output logic        f_rsp_valid,
    input  logic        f_rsp_ready,
    output logic [31:0] f_rsp_data,
    output logic        f_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic [31:0] mem_a,
    input  logic [31:0] mem_rd
);

    localparam logic [3:0] LP_MAX_RUN = 4'(MAX_FETCH_RUN);

    logic        r_f_valid;
    logic [31:0] r_f_data;
    logic        r_f_err;
    logic        r_d_valid;
    logic [31:0] r_d_data;
    logic        r_d_err;
    logic [3:0]  r_starve_cnt;

    logic        w_f_elig;
    logic        w_d_elig;
    logic        w_force_d;
    logic        w_grant_f;
    logic        w_grant_d;
    logic        w_aligned;
    logic [31:0] w_load_data;

    // A slot counts as free when it is empty or being drained this very cycle.
    assign w_f_elig  = f_req_valid & (~r_f_valid | f_rsp_ready);
    assign w_d_elig  = d_req_valid & (~r_d_valid | d_rsp_ready);
    assign w_force_d = (r_starve_cnt == LP_MAX_RUN) & w_d_elig;
    assign w_grant_f = w_f_elig & ~w_force_d;
    assign w_grant_d = w_d_elig & (w_force_d | ~w_f_elig);

    assign f_req_ready = w_grant_f;
    assign d_req_ready = w_grant_d;

    always_comb begin
        mem_a = 32'h0;
        if (w_grant_f) begin
            mem_a = f_req_addr;
        end else if (w_grant_d) begin
            mem_a = d_req_addr;
        end
    end

    assign w_aligned   = (mem_a[1:0] == 2'b00);
    assign w_load_data = w_aligned ? mem_rd : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_valid <= 1'b0;
            r_f_data  <= 32'h0;
            r_f_err   <= 1'b0;
        end else if (w_grant_f) begin
            r_f_valid <= 1'b1;
            r_f_data  <= w_load_data;
            r_f_err   <= ~w_aligned;
        end else if (r_f_valid && f_rsp_ready) begin
            r_f_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_valid <= 1'b0;
            r_d_data  <= 32'h0;
            r_d_err   <= 1'b0;
        end else if (w_grant_d) begin
            r_d_valid <= 1'b1;
            r_d_data  <= w_load_data;
            r_d_err   <= ~w_aligned;
        end else if (r_d_valid && d_rsp_ready) begin
            r_d_valid <= 1'b0;
        end
    end

    // Counts only cycles where debug could have been served but fetch took the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'h0;
        end else if (w_grant_d || !d_req_valid) begin
            r_starve_cnt <= 4'h0;
        end else if (w_d_elig && w_grant_f && (r_starve_cnt != LP_MAX_RUN)) begin
            r_starve_cnt <= r_starve_cnt + 4'h1;
        end
    end

    assign f_rsp_valid = r_f_valid;
    assign f_rsp_data  = r_f_data;
    assign f_rsp_err   = r_f_err;
    assign d_rsp_valid = r_d_valid;
    assign d_rsp_data  = r_d_data;
    assign d_rsp_err   = r_d_err;

endmodule
